apb_master_bridge: RTL and testbench

- APB initiator converting a simple valid/ready command stream into APB transfers toward the FIFO-backed APB slave; a valid/ready response stream carries the result back.
- Two slave selects (psel_0 = write-side slave, psel_1 = read-side slave), decoded from one command address bit.
- A cycle-count timeout guards against slaves that never assert pready.
- Sits between a host/DMA command source and the APB peripheral bus.

---
 rtl/apb_master_bridge_pkg.sv | 14 +
 rtl/apb_master_bridge_if.sv | 35 +++
 rtl/apb_master_bridge_timeout_cnt.sv | 20 ++
 rtl/apb_master_bridge.sv | 97 +++++++++
 tb/tb_apb_master_bridge.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/apb_master_bridge_pkg.sv
// apb_pkg: shared state encodings and default widths for the APB master bridge
package apb_pkg;
  localparam int PDATA_W_DEF = 32;
  localparam int PADDR_W_DEF = 32;
  localparam int SEL_BIT_DEF = 12;
  localparam int TIMEOUT_DEF = 16;
  localparam int TO_W_DEF = 5;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;
endpackage

// File: rtl/apb_master_bridge_if.sv
// apb_master_bridge_if: command/response streams plus APB bus of the bridge
interface apb_master_bridge_if #(
  parameter int PDATA_WIDTH = 32,
  parameter int PADDR_WIDTH = 32
);
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic                   cmd_write;
  logic [PADDR_WIDTH-1:0] cmd_addr;
  logic [PDATA_WIDTH-1:0] cmd_wdata;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [PDATA_WIDTH-1:0] rsp_rdata;
  logic                   rsp_err;
  logic                   rsp_timeout;
  logic [PADDR_WIDTH-1:0] paddr;
  logic                   pwrite;
  logic                   psel_0;
  logic                   psel_1;
  logic                   penable;
  logic [PDATA_WIDTH-1:0] pwdata;
  logic [PDATA_WIDTH-1:0] prdata;
  logic                   pready;
  logic                   pslverr;
  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, prdata, pready, pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           paddr, pwrite, psel_0, psel_1, penable, pwdata
  );
  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, prdata, pready, pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           paddr, pwrite, psel_0, psel_1, penable, pwdata
  );
endinterface

// File: rtl/apb_master_bridge_timeout_cnt.sv
// apb_timeout_cnt: counts ACCESS wait cycles and flags the last allowed one
module apb_timeout_cnt #(
  parameter int TIMEOUT_CYC = 16,
  parameter int TO_W = 5
) (
  input  logic pclk,
  input  logic preset_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  logic [TO_W-1:0] cnt_q, cnt_d;
  // next count: clear wins over increment
  always_comb cnt_d = clr_i ? '0 : en_i ? cnt_q + TO_W'(1) : cnt_q;
  // count register
  always_ff @(posedge pclk or negedge preset_n)
    if (!preset_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign expired_o = cnt_q == TO_W'(TIMEOUT_CYC - 1);
endmodule

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: valid/ready command stream to APB transfer with timeout
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int PDATA_WIDTH = PDATA_W_DEF,
  parameter int PADDR_WIDTH = PADDR_W_DEF,
  parameter int SEL_BIT = SEL_BIT_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_DEF,
  parameter int TO_W = TO_W_DEF
) (
  input logic pclk,
  input logic preset_n,
  apb_master_bridge_if.master bus
);
  state_e                 state_q;
  logic                   cmd_ready_q, rsp_valid_q, rsp_err_q, rsp_timeout_q;
  logic                   pwrite_q, psel0_q, psel1_q, penable_q;
  logic [PDATA_WIDTH-1:0] rsp_rdata_q, pwdata_q;
  logic [PADDR_WIDTH-1:0] paddr_q;
  logic                   expired;
  apb_timeout_cnt #(.TIMEOUT_CYC(TIMEOUT_CYC), .TO_W(TO_W)) u_to (
    .pclk(pclk),
    .preset_n(preset_n),
    .clr_i(state_q != ACCESS),
    .en_i(state_q == ACCESS && !bus.pready),
    .expired_o(expired)
  );
  // transfer sequencer with all outputs registered
  always_ff @(posedge pclk or negedge preset_n)
    if (!preset_n) begin
      state_q       <= IDLE;
      cmd_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      paddr_q       <= '0;
      pwrite_q      <= 1'b0;
      psel0_q       <= 1'b0;
      psel1_q       <= 1'b0;
      penable_q     <= 1'b0;
      pwdata_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          cmd_ready_q <= 1'b1;
          if (bus.cmd_valid && cmd_ready_q) begin
            paddr_q     <= bus.cmd_addr;
            pwrite_q    <= bus.cmd_write;
            pwdata_q    <= bus.cmd_wdata;
            psel0_q     <= !bus.cmd_addr[SEL_BIT];
            psel1_q     <= bus.cmd_addr[SEL_BIT];
            cmd_ready_q <= 1'b0;
            state_q     <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
        end
        ACCESS:
          if (bus.pready || expired) begin
            rsp_rdata_q   <= (bus.pready && !pwrite_q && !bus.pslverr) ? bus.prdata : '0;
            rsp_err_q     <= bus.pready ? bus.pslverr : 1'b1;
            rsp_timeout_q <= !bus.pready;
            psel0_q       <= 1'b0;
            psel1_q       <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            state_q       <= RESP;
          end
        RESP:
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        default: begin
          psel0_q   <= 1'b0;
          psel1_q   <= 1'b0;
          penable_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_timeout_q;
  assign bus.paddr       = paddr_q;
  assign bus.pwrite      = pwrite_q;
  assign bus.psel_0      = psel0_q;
  assign bus.psel_1      = psel1_q;
  assign bus.penable     = penable_q;
  assign bus.pwdata      = pwdata_q;
endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: directed table-driven bench for the APB master bridge
module tb_apb_master_bridge;
  logic pclk = 1'b0;
  logic preset_n = 1'b0;
  int checks = 0;
  int errors = 0;
  apb_master_bridge_if #(.PDATA_WIDTH(32), .PADDR_WIDTH(32)) bus ();
  apb_master_bridge dut (.pclk(pclk), .preset_n(preset_n), .bus(bus));
  always #5 pclk = ~pclk;
  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] prdata;
    int          waits;
    logic        slverr;
    logic        hang;
    logic [31:0] e_rdata;
    logic        e_err;
    logic        e_to;
    logic        e_sel1;
    int          e_lat;
    int          e_acc;
  } vec_t;
  vec_t tv [7];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic run_vec(input int n, input vec_t v);
    int lat;
    int acc;
    bit got;
    bit sel0_seen;
    bit sel1_seen;
    @(negedge pclk);
    chk($sformatf("v%0d cmd_ready idle", n), 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = v.wr;
    bus.cmd_addr  = v.addr;
    bus.cmd_wdata = v.wdata;
    bus.rsp_ready = 1'b1;
    bus.pready    = 1'b0;
    @(posedge pclk);
    lat = 1;
    @(negedge pclk);
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = 32'hFFFF_FFFF;
    chk($sformatf("v%0d setup psel_0", n), 32'(bus.psel_0), 32'(!v.e_sel1));
    chk($sformatf("v%0d setup psel_1", n), 32'(bus.psel_1), 32'(v.e_sel1));
    chk($sformatf("v%0d setup penable", n), 32'(bus.penable), 32'd0);
    chk($sformatf("v%0d setup pwrite", n), 32'(bus.pwrite), 32'(v.wr));
    chk($sformatf("v%0d setup paddr", n), bus.paddr, v.addr);
    if (v.wr) chk($sformatf("v%0d setup pwdata", n), bus.pwdata, v.wdata);
    chk($sformatf("v%0d setup cmd_ready", n), 32'(bus.cmd_ready), 32'd0);
    @(posedge pclk);
    lat++;
    @(negedge pclk);
    chk($sformatf("v%0d access penable", n), 32'(bus.penable), 32'd1);
    acc = 0;
    got = 0;
    sel0_seen = bus.psel_0;
    sel1_seen = bus.psel_1;
    for (int k = 0; k < 40 && !got; k++) begin
      bus.pready  = !v.hang && acc == v.waits;
      bus.prdata  = bus.pready ? v.prdata : 32'hFFFF_FFFF;
      bus.pslverr = bus.pready ? v.slverr : 1'b1;
      @(posedge pclk);
      lat++;
      @(negedge pclk);
      bus.pready = 1'b0;
      if (bus.rsp_valid) got = 1;
      else begin
        acc++;
        sel0_seen |= bus.psel_0;
        sel1_seen |= bus.psel_1;
        if (!bus.penable || bus.paddr !== v.addr) chk($sformatf("v%0d access hold", n), {bus.paddr[30:0], bus.penable}, {v.addr[30:0], 1'b1});
      end
    end
    chk($sformatf("v%0d rsp_valid seen", n), 32'(got), 32'd1);
    chk($sformatf("v%0d latency", n), 32'(lat), 32'(v.e_lat));
    chk($sformatf("v%0d access cycles", n), 32'(acc + 1), 32'(v.e_acc));
    chk($sformatf("v%0d other psel never", n), 32'(v.e_sel1 ? sel0_seen : sel1_seen), 32'd0);
    chk($sformatf("v%0d rsp_rdata", n), bus.rsp_rdata, v.e_rdata);
    chk($sformatf("v%0d rsp_err", n), 32'(bus.rsp_err), 32'(v.e_err));
    chk($sformatf("v%0d rsp_timeout", n), 32'(bus.rsp_timeout), 32'(v.e_to));
    chk($sformatf("v%0d psel dropped", n), {30'd0, bus.psel_0 | bus.psel_1, bus.penable}, 32'd0);
    @(posedge pclk);
    @(negedge pclk);
    chk($sformatf("v%0d rsp consumed", n), {30'd0, bus.rsp_valid, bus.cmd_ready}, 32'd1);
  endtask
  initial begin
    bit bad;
    bit got;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0;
    bus.prdata    = '0;
    bus.pready    = 1'b0;
    bus.pslverr   = 1'b0;
    tv[0] = '{1'b1, 32'h0000_0010, 32'hA5A5_0001, 32'h0, 0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 3, 1};
    tv[1] = '{1'b0, 32'h0000_1000, 32'h0, 32'hDEAD_BEEF, 2, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 5, 3};
    tv[2] = '{1'b0, 32'h0000_1004, 32'h0, 32'h1234_5678, 0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 3, 1};
    tv[3] = '{1'b0, 32'h0000_1008, 32'h0, 32'h5555_AAAA, 0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b1, 1'b1, 18, 16};
    tv[4] = '{1'b1, 32'h0000_1FFC, 32'h0F0F_0F0F, 32'h7777_7777, 1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 4, 2};
    tv[5] = '{1'b0, 32'hFFFF_E020, 32'h0, 32'h0BAD_F00D, 0, 1'b0, 1'b0, 32'h0BAD_F00D, 1'b0, 1'b0, 1'b0, 3, 1};
    tv[6] = '{1'b1, 32'h0000_0044, 32'h1357_9BDF, 32'h0, 15, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 18, 16};
    #12;
    chk("reset outputs", {21'd0, bus.cmd_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout,
        bus.pwrite, bus.psel_0, bus.psel_1, bus.penable, 3'd0}, 32'd0);
    chk("reset buses", bus.paddr | bus.pwdata | bus.rsp_rdata, 32'd0);
    @(negedge pclk);
    preset_n = 1'b1;
    #1 chk("cmd_ready before first edge", 32'(bus.cmd_ready), 32'd0);
    @(posedge pclk);
    @(negedge pclk);
    chk("cmd_ready after first edge", 32'(bus.cmd_ready), 32'd1);
    for (int i = 0; i < 7; i++) run_vec(i, tv[i]);
    // response backpressure: response held, new command refused until consumed
    @(negedge pclk);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 32'h0000_0080;
    bus.rsp_ready = 1'b0;
    bus.pready    = 1'b1;
    bus.pslverr   = 1'b0;
    bus.prdata    = 32'hCAFE_F00D;
    @(posedge pclk);
    @(negedge pclk);
    bus.cmd_valid = 1'b0;
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    chk("hold rsp_valid up", 32'(bus.rsp_valid), 32'd1);
    bus.pready    = 1'b0;
    bus.prdata    = 32'h0;
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = 32'h0000_1000;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge pclk);
      @(negedge pclk);
      if (!bus.rsp_valid || bus.rsp_rdata !== 32'hCAFE_F00D || bus.rsp_err || bus.cmd_ready || bus.psel_0 || bus.psel_1) bad = 1;
    end
    chk("hold rsp stable and cmd refused", 32'(bad), 32'd0);
    chk("hold rdata", bus.rsp_rdata, 32'hCAFE_F00D);
    bus.rsp_ready = 1'b1;
    @(posedge pclk);
    @(negedge pclk);
    chk("release to idle", {29'd0, bus.rsp_valid, bus.cmd_ready, bus.psel_1}, 32'd2);
    @(posedge pclk);
    @(negedge pclk);
    bus.cmd_valid = 1'b0;
    chk("next cmd accepted", {30'd0, bus.psel_1, bus.penable}, 32'd2);
    bus.pready = 1'b1;
    got = 0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(posedge pclk);
      @(negedge pclk);
      got = bus.cmd_ready;
    end
    chk("drain back to idle", 32'(got), 32'd1);
    bus.pready = 1'b0;
    // asynchronous reset in the middle of ACCESS
    @(negedge pclk);
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = 32'h0000_0100;
    @(posedge pclk);
    @(negedge pclk);
    bus.cmd_valid = 1'b0;
    @(posedge pclk);
    @(negedge pclk);
    chk("pre-reset access", {30'd0, bus.psel_0, bus.penable}, 32'd3);
    @(posedge pclk);
    #2 preset_n = 1'b0;
    #1 chk("async reset drops bus", {28'd0, bus.psel_0, bus.psel_1, bus.penable, bus.rsp_valid}, 32'd0);
    chk("async reset cmd_ready", 32'(bus.cmd_ready), 32'd0);
    bus.pready = 1'b1;
    repeat (2) @(negedge pclk);
    preset_n = 1'b1;
    @(posedge pclk);
    @(negedge pclk);
    chk("post-reset cmd_ready", 32'(bus.cmd_ready), 32'd1);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge pclk);
      if (bus.rsp_valid || bus.psel_0 || bus.psel_1) bad = 1;
    end
    chk("no stale response", 32'(bad), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
